prga_fifo_family: RTL and testbench



---
 rtl/prga_fifo_family_if.sv | 14 +
 rtl/prga_fifo_family.sv | 141 ++++++++++++++
 tb/tb_prga_fifo_family.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/prga_fifo_family_if.sv
// FIFO-style handshake bundle: write side (wr/din/full) and read side (rd/dout/empty).
interface prga_fifo_family_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  rd;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;

    modport master (output wr, din, rd, input full, dout, empty);
    modport slave  (input wr, din, rd, output full, dout, empty);
endinterface

// File: rtl/prga_fifo_family.sv
// Single-clock FIFO, read-port style adapter, and a top that exposes the four
// useful combinations (plain FIFOs of both styles and FIFO+adapter chains).
module prga_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_WIDTH = 32,
    parameter int LOOKAHEAD  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  full,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  empty,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  wr_acc, rd_acc;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = wr_ptr_q == rd_ptr_q;
    assign full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}};
    assign wr_acc   = wr & ~full;
    assign rd_acc   = rd & ~empty;
    assign wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, wr_acc};
    assign rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, rd_acc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
    end

    generate
        if (LOOKAHEAD != 0) begin : g_la
            assign dout = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
        end else begin : g_nla
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)        dout_q <= '0;
                else if (rd_acc) dout_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
            end
            assign dout = dout_q;
        end
    endgenerate
endmodule

module prga_fifo_lookahead_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int REVERSED   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty_i,
    output logic                  rd_i,
    input  logic [DATA_WIDTH-1:0] dout_i,
    output logic                  empty,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout
);
    generate
        if (REVERSED == 0) begin : g_fwd
            // valid_q: the upstream output register holds a word not yet consumed.
            logic valid_q, valid_d;
            assign rd_i    = ~empty_i & (~valid_q | rd);
            assign valid_d = rd_i ? 1'b1 : (rd ? 1'b0 : valid_q);
            assign empty   = ~valid_q;
            assign dout    = dout_i;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) valid_q <= 1'b0;
                else      valid_q <= valid_d;
            end
        end else begin : g_rev
            logic [DATA_WIDTH-1:0] dout_q;
            assign rd_i  = rd & ~empty_i;
            assign empty = empty_i;
            assign dout  = dout_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)      dout_q <= '0;
                else if (rd_i) dout_q <= dout_i;
            end
        end
    endgenerate
endmodule

module prga_fifo_family #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    prga_fifo_family_if.slave  la0_if,
    prga_fifo_family_if.slave  la1_if,
    prga_fifo_family_if.slave  nla2la_if,
    prga_fifo_family_if.slave  la2nla_if,
    output logic               nla2la_rd_i_o,
    output logic               la2nla_rd_i_o
);
    logic                  c_empty, c_rd, d_empty, d_rd;
    logic [DATA_WIDTH-1:0] c_dout, d_dout;

    prga_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_WIDTH(DATA_WIDTH), .LOOKAHEAD(0)) u_la0 (
        .clk(clk), .rst(rst), .full(la0_if.full), .wr(la0_if.wr), .din(la0_if.din),
        .empty(la0_if.empty), .rd(la0_if.rd), .dout(la0_if.dout));

    prga_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_WIDTH(DATA_WIDTH), .LOOKAHEAD(1)) u_la1 (
        .clk(clk), .rst(rst), .full(la1_if.full), .wr(la1_if.wr), .din(la1_if.din),
        .empty(la1_if.empty), .rd(la1_if.rd), .dout(la1_if.dout));

    // Non-lookahead FIFO presented as lookahead.
    prga_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_WIDTH(DATA_WIDTH), .LOOKAHEAD(0)) u_c_fifo (
        .clk(clk), .rst(rst), .full(nla2la_if.full), .wr(nla2la_if.wr), .din(nla2la_if.din),
        .empty(c_empty), .rd(c_rd), .dout(c_dout));

    prga_fifo_lookahead_buffer #(.DATA_WIDTH(DATA_WIDTH), .REVERSED(0)) u_c_buf (
        .clk(clk), .rst(rst), .empty_i(c_empty), .rd_i(c_rd), .dout_i(c_dout),
        .empty(nla2la_if.empty), .rd(nla2la_if.rd), .dout(nla2la_if.dout));

    // Lookahead FIFO presented as non-lookahead.
    prga_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_WIDTH(DATA_WIDTH), .LOOKAHEAD(1)) u_d_fifo (
        .clk(clk), .rst(rst), .full(la2nla_if.full), .wr(la2nla_if.wr), .din(la2nla_if.din),
        .empty(d_empty), .rd(d_rd), .dout(d_dout));

    prga_fifo_lookahead_buffer #(.DATA_WIDTH(DATA_WIDTH), .REVERSED(1)) u_d_buf (
        .clk(clk), .rst(rst), .empty_i(d_empty), .rd_i(d_rd), .dout_i(d_dout),
        .empty(la2nla_if.empty), .rd(la2nla_if.rd), .dout(la2nla_if.dout));

    assign nla2la_rd_i_o = c_rd;
    assign la2nla_rd_i_o = d_rd;
endmodule

// File: tb/tb_prga_fifo_family.sv
// Directed and random checks of all four FIFO/adapter combinations against queue models.
module tb_prga_fifo_family;
    localparam int DW  = 32;
    localparam int DL  = 3;
    localparam int CAP = 1 << DL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prga_fifo_family_if #(.DATA_WIDTH(DW)) a_if ();
    prga_fifo_family_if #(.DATA_WIDTH(DW)) b_if ();
    prga_fifo_family_if #(.DATA_WIDTH(DW)) c_if ();
    prga_fifo_family_if #(.DATA_WIDTH(DW)) d_if ();
    logic c_rdi, d_rdi;

    prga_fifo_family #(.DEPTH_LOG2(DL), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .la0_if(a_if), .la1_if(b_if), .nla2la_if(c_if), .la2nla_if(d_if),
        .nla2la_rd_i_o(c_rdi), .la2nla_rd_i_o(d_rdi));

    // Reference: word queues per path, output registers, and the adapter's held-word flag.
    logic [DW-1:0] qa[$], qb[$], qc[$], qd[$];
    logic [DW-1:0] a_dreg, c_ureg, d_dreg;
    logic          c_vld;
    int errs = 0;
    int checks = 0;

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete(); qc.delete(); qd.delete();
        a_dreg = '0; c_ureg = '0; d_dreg = '0; c_vld = 1'b0;
    endtask

    task automatic check_all();
        chk("a_empty", a_if.empty, qa.size() == 0);
        chk("a_full",  a_if.full,  qa.size() == CAP);
        chk("a_dout",  a_if.dout,  a_dreg);
        chk("b_empty", b_if.empty, qb.size() == 0);
        chk("b_full",  b_if.full,  qb.size() == CAP);
        if (qb.size() > 0) chk("b_dout", b_if.dout, qb[0]);
        chk("c_empty", c_if.empty, !c_vld);
        chk("c_full",  c_if.full,  qc.size() == CAP);
        if (c_vld) chk("c_dout", c_if.dout, c_ureg);
        chk("c_rd_i",  c_rdi, (qc.size() > 0) && (!c_vld || c_if.rd));
        chk("d_empty", d_if.empty, qd.size() == 0);
        chk("d_full",  d_if.full,  qd.size() == CAP);
        chk("d_dout",  d_if.dout,  d_dreg);
        chk("d_rd_i",  d_rdi, d_if.rd && (qd.size() > 0));
    endtask

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit wa, ra, wb, rb, wc, rdi, wd, rd_;
        wa = a_if.wr && qa.size() < CAP;  ra = a_if.rd && qa.size() > 0;
        wb = b_if.wr && qb.size() < CAP;  rb = b_if.rd && qb.size() > 0;
        wc = c_if.wr && qc.size() < CAP;  rdi = (qc.size() > 0) && (!c_vld || c_if.rd);
        wd = d_if.wr && qd.size() < CAP;  rd_ = d_if.rd && qd.size() > 0;
        if (ra) a_dreg = qa.pop_front();
        if (wa) qa.push_back(a_if.din);
        if (rb) void'(qb.pop_front());
        if (wb) qb.push_back(b_if.din);
        if (rdi) begin c_ureg = qc.pop_front(); c_vld = 1'b1; end
        else if (c_if.rd) c_vld = 1'b0;
        if (wc) qc.push_back(c_if.din);
        if (rd_) d_dreg = qd.pop_front();
        if (wd) qd.push_back(d_if.din);
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(logic w, logic [DW-1:0] d, logic r);
        a_if.wr = w; a_if.din = d; a_if.rd = r;
        b_if.wr = w; b_if.din = d; b_if.rd = r;
        c_if.wr = w; c_if.din = d; c_if.rd = r;
        d_if.wr = w; d_if.din = d; d_if.rd = r;
    endtask

    task automatic rst_chk(string tag);
        chk({tag, "_a_empty"}, a_if.empty, 1'b1);
        chk({tag, "_b_empty"}, b_if.empty, 1'b1);
        chk({tag, "_c_empty"}, c_if.empty, 1'b1);
        chk({tag, "_d_empty"}, d_if.empty, 1'b1);
        chk({tag, "_a_full"},  a_if.full,  1'b0);
        chk({tag, "_a_dout"},  a_if.dout,  '0);
        chk({tag, "_d_dout"},  d_if.dout,  '0);
        chk({tag, "_c_rd_i"},  c_rdi, 1'b0);
        chk({tag, "_d_rd_i"},  d_rdi, 1'b0);
    endtask

    // Asynchronous reset pulse taken off-edge; reset values must appear before any clock.
    task automatic async_reset(string tag);
        #2 rst = 1'b0;
        #1 rst_chk(tag);
        model_reset();
        set_all(1'b0, '0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        set_all(1'b0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_chk("por");
        rst = 1'b1;
        tick();

        // Fill 0x11..0x88, then a 9th write that the full FIFO must drop.
        for (int i = 1; i <= 8; i++) begin
            set_all(1'b1, DW'(i * 'h11), 1'b0);
            tick();
        end
        chk("a_full_after_8", a_if.full, 1'b1);
        set_all(1'b1, 'h99, 1'b0);
        tick();
        chk("a_full_after_9", a_if.full, 1'b1);
        set_all(1'b0, '0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i <= 8) chk("a_drain_dout", a_if.dout, DW'(i * 'h11));
        end
        chk("a_empty_after_drain", a_if.empty, 1'b1);
        chk("a_dout_hold", a_if.dout, 'h88);

        // Lookahead port: written word visible as soon as empty falls.
        set_all(1'b1, 'hA5, 1'b0);
        tick();
        chk("b_empty_after_wr", b_if.empty, 1'b0);
        chk("b_dout_a5", b_if.dout, 'hA5);
        set_all(1'b0, '0, 1'b1);
        tick();
        chk("b_empty_after_rd", b_if.empty, 1'b1);

        // Simultaneous write+read on full then on empty.
        async_reset("mid1");
        for (int i = 0; i < 8; i++) begin
            set_all(1'b1, DW'('h100 + i), 1'b0);
            tick();
        end
        set_all(1'b1, 'hEE, 1'b1);
        tick();
        chk("a_full_wr_rd", a_if.full, 1'b0);
        chk("a_dout_wr_rd", a_if.dout, 'h100);
        set_all(1'b0, '0, 1'b1);
        repeat (8) tick();
        chk("a_dout_no_ee", a_if.dout, 'h107);
        set_all(1'b1, 'hCC, 1'b1);
        tick();
        chk("a_empty_wr_rd", a_if.empty, 1'b0);
        chk("a_dout_rd_ignored", a_if.dout, 'h107);
        set_all(1'b0, '0, 1'b1);
        tick();
        chk("a_dout_cc", a_if.dout, 'hCC);

        // Non-lookahead upstream through the forward adapter: 1,2,3 back to back.
        async_reset("mid2");
        for (int i = 1; i <= 3; i++) begin
            set_all(1'b1, DW'(i), 1'b0);
            tick();
        end
        set_all(1'b0, '0, 1'b0);
        repeat (2) tick();
        set_all(1'b0, '0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            #1 chk("c_stream_empty", c_if.empty, 1'b0);
            chk("c_stream_dout", c_if.dout, DW'(i));
            tick();
        end
        chk("c_empty_after_3", c_if.empty, 1'b1);
        set_all(1'b0, '0, 1'b0);
        tick();
        chk("c_stall_rd_i", c_rdi, 1'b0);

        // Lookahead upstream through the reversed adapter.
        async_reset("mid3");
        set_all(1'b1, 'h5A, 1'b0); tick();
        set_all(1'b1, 'h3C, 1'b0); tick();
        set_all(1'b0, '0, 1'b1);   tick();
        chk("d_dout_5a", d_if.dout, 'h5A);
        set_all(1'b0, '0, 1'b0);   tick();
        set_all(1'b0, '0, 1'b1);   tick();
        chk("d_dout_3c", d_if.dout, 'h3C);
        chk("d_empty_after_2", d_if.empty, 1'b1);
        chk("d_rd_i_when_empty", d_rdi, 1'b0);
        tick();
        chk("d_dout_stable", d_if.dout, 'h3C);

        // Random traffic, independent per path, with a reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) async_reset("rand");
            a_if.wr = 1'($urandom_range(0, 1)); a_if.din = $urandom; a_if.rd = 1'($urandom_range(0, 2) == 0);
            b_if.wr = 1'($urandom_range(0, 1)); b_if.din = $urandom; b_if.rd = 1'($urandom_range(0, 1));
            c_if.wr = 1'($urandom_range(0, 2) != 0); c_if.din = $urandom; c_if.rd = 1'($urandom_range(0, 1));
            d_if.wr = 1'($urandom_range(0, 1)); d_if.din = $urandom; d_if.rd = 1'($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
